// File: rtl/alu_cmd_sequencer.sv
// Registered command front-end for the 8-bit combinational ALU: accepts one command,
// holds A/B/op stable for the ALU, captures the result, and keeps an accumulator for chaining.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             cmd_acc_wr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    // state | meaning
    // IDLE  | ready for a command; ALU inputs hold their last values
    // ISSUE | ALU inputs registered, one cycle for the ALU to settle
    // HOLD  | result held until the consumer takes it
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [2:0] ILLEGAL_OP = 3'b111;

    logic [1:0] state;
    logic       acc_wr_q;
    logic       illegal_q;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_wr_q  <= 1'b0;
            illegal_q <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= cmd_use_acc ? acc : cmd_a;
                        alu_b     <= cmd_b;
                        alu_op    <= cmd_op;
                        acc_wr_q  <= cmd_acc_wr;
                        illegal_q <= (cmd_op == ILLEGAL_OP);
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // an illegal opcode never lets the ALU output reach res_data or acc
                    res_data  <= illegal_q ? '0 : alu_out;
                    res_err   <= illegal_q;
                    res_valid <= 1'b1;
                    if (acc_wr_q && !illegal_q) begin
                        acc <= alu_out;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        if (!illegal_q) begin
                            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Registered command front-end that sits directly upstream of the 8-bit combinational ALU (ops: NOT, OR, XOR, AND, 4x4 MUL, ADD, SUB). It accepts one command at a time over a valid/ready handshake and drives stable A/B/op into the ALU. It captures the ALU result into a held output register with its own valid/ready handshake. An internal accumulator can stand in for operand A, so multi-step computations can be chained without re-sending intermediate results.

Parameters:
WIDTH, 8, datapath width; must match the ALU operand/result width.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  3  ALU opcode: 000 NOT A, 001 OR, 010 XOR, 011 AND, 100 MUL low nibbles, 101 ADD, 110 SUB, 111 illegal.
cmd_a  input  WIDTH  operand A; ignored when cmd_use_acc=1.
cmd_b  input  WIDTH  operand B.
cmd_use_acc  input  1  take A from the accumulator.
cmd_acc_wr  input  1  write the result into the accumulator on capture.
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_op  output  3  to ALU op.
alu_out  input  WIDTH  ALU result (combinational).
res_valid  output  1  result held.
res_ready  input  1  consumer takes the result.
res_data  output  WIDTH  captured result.
res_err  output  1  qualifies res_valid: command had an illegal opcode.
acc  output  WIDTH  accumulator value.
op_count  output  CNT_W  number of legal results delivered (wraps).

Behaviour:
- Reset is asynchronous and active-high. It sets state=IDLE, cmd_ready=1, res_valid=0, res_err=0, and clears res_data, acc, alu_a, alu_b, alu_op and op_count to 0. A reset mid-operation aborts the operation immediately, with no partial accumulator write.
- FSM states are IDLE, ISSUE, HOLD.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge T:
  - Register alu_a = cmd_use_acc ? acc : cmd_a, alu_b = cmd_b, alu_op = cmd_op.
  - Latch cmd_acc_wr and the illegal flag (cmd_op==111).
  - Go to ISSUE.
- ISSUE: exactly one cycle; cmd_ready=0, and alu_* stay stable so the ALU settles. At edge T+1:
  - Set res_data = alu_out, or 0 if illegal.
  - Set res_err = illegal flag and res_valid=1.
  - If the latched acc_wr is set and the op is legal, acc <= alu_out.
  - Go to HOLD.
  - Latency: res_valid is visible in the cycle after edge T+1, two cycles after acceptance.
- HOLD: cmd_ready=0. res_valid, res_data and res_err hold until res_ready is sampled high. On that edge:
  - Clear res_valid and res_err.
  - Increment op_count if the result was legal (modulo 2^CNT_W).
  - Go to IDLE. The next command can be accepted no earlier than the following edge, so there is no same-cycle pass-through.
- res_ready asserted while res_valid=0 has no effect.
- cmd_valid during ISSUE/HOLD is ignored; the upstream source must hold the command until cmd_ready.
- alu_a/alu_b/alu_op keep their last values in IDLE/HOLD; they change only on acceptance.
- Arithmetic is the ALU's, truncated to WIDTH: ADD/SUB wrap modulo 256, and MUL uses only A[3:0]*B[3:0] with an 8-bit product. The sequencer performs no arithmetic itself.
- An illegal op never drives the ALU result anywhere. It is reported only as res_err with res_data=0, and acc is untouched.
- Peak throughput is one result every 3 cycles when res_ready is held at 1.

Test Plan:
- Reset, then OR with A=F0, B=0F, use_acc=0 -> res_valid 2 cycles after accept, res_data=FF, res_err=0; op_count=1 after res_ready.
- Chain: ADD A=F0, B=20, acc_wr=1 -> res=10 (wrap), acc=10. Then SUB use_acc=1, B=11, acc_wr=1 -> res=FF, acc=FF. Then NOT use_acc=1 -> res=00.
- MUL A=F3, B=A5 -> res_data=0F (3*5, upper nibbles ignored). Then MUL A=0F, B=0F -> E1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stable, cmd_ready=0, and a second command presented meanwhile is accepted only after res_ready plus one edge.
- Illegal op=111 with acc_wr=1, acc=55 -> res_err=1, res_data=00, acc stays 55, op_count unchanged.
- Assert rst during ISSUE of ADD with acc_wr=1 -> all outputs 0 immediately (asynchronous), acc=00, cmd_ready=1 after release, no res_valid.
